// File: rtl/fp_mult_pipe.sv
// Multi-lane IEEE-754 binary32 multiplier: 3-stage pipeline (classify, multiply, round/pack)
// with flush-to-zero inputs/outputs, round-to-nearest-even and a valid/ready handshake.
module fp_mult_pipe #(
    parameter int LANES = 1,
    parameter int W     = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               valid_in,
    output logic               ready_out,
    input  logic [LANES*W-1:0] a,
    input  logic [LANES*W-1:0] b,
    output logic [LANES*W-1:0] out,
    output logic [3:0]         flags,
    output logic               valid_out,
    input  logic               ready_in
);
    if (W != 32) begin : g_bad_width
        $fatal(1, "fp_mult_pipe: W must be 32");
    end
    if (LANES < 1 || LANES > 8) begin : g_bad_lanes
        $fatal(1, "fp_mult_pipe: LANES must be 1..8");
    end

    localparam logic [1:0] K_NORM = 2'd0;
    localparam logic [1:0] K_ZERO = 2'd1;
    localparam logic [1:0] K_INF  = 2'd2;
    localparam logic [1:0] K_NAN  = 2'd3;

    logic       adv;
    logic       valid1_reg, valid2_reg, valid_out_reg;
    logic [3:0] flags_reg, flags_next;
    logic [3:0] lane_flags_next [LANES];

    assign adv       = ~valid_out_reg | ready_in;
    assign ready_out = adv;
    assign valid_out = valid_out_reg;
    assign flags     = flags_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid1_reg    <= 1'b0;
            valid2_reg    <= 1'b0;
            valid_out_reg <= 1'b0;
            flags_reg     <= 4'd0;
        end else if (adv) begin
            valid1_reg    <= valid_in;
            valid2_reg    <= valid1_reg;
            valid_out_reg <= valid2_reg;
            // Bubbles leave the last result and its flags visible
            if (valid2_reg)
                flags_reg <= flags_next;
        end
    end

    always_comb begin
        flags_next = 4'd0;
        for (int i = 0; i < LANES; i++)
            flags_next = flags_next | lane_flags_next[i];
    end

    genvar gi;
    for (gi = 0; gi < LANES; gi++) begin : g_lane
        logic [31:0]       op_a, op_b;
        logic              zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
        logic [1:0]        kind_s1;
        logic signed [9:0] exp_sum;

        logic              sign1_reg, sign2_reg;
        logic [1:0]        kind1_reg, kind2_reg;
        logic signed [9:0] exp1_reg, exp2_reg;
        logic [23:0]       ma1_reg, mb1_reg;
        logic [47:0]       prod2_reg;
        logic [31:0]       out_reg, res_next;
        logic [3:0]        flg_next;

        logic [22:0]       frac, frac_r;
        logic              guard, rnd, sticky, round_up, carry, inexact;
        logic signed [9:0] exp_n, exp_f;

        assign op_a   = a[gi*32 +: 32];
        assign op_b   = b[gi*32 +: 32];
        assign zero_a = (op_a[30:23] == 8'd0);
        assign zero_b = (op_b[30:23] == 8'd0);
        assign inf_a  = (op_a[30:23] == 8'hFF) && (op_a[22:0] == 23'd0);
        assign inf_b  = (op_b[30:23] == 8'hFF) && (op_b[22:0] == 23'd0);
        assign nan_a  = (op_a[30:23] == 8'hFF) && (op_a[22:0] != 23'd0);
        assign nan_b  = (op_b[30:23] == 8'hFF) && (op_b[22:0] != 23'd0);
        assign exp_sum = $signed({2'b00, op_a[30:23]}) + $signed({2'b00, op_b[30:23]}) - 10'sd127;

        always_comb begin
            kind_s1 = K_NORM;
            if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a))
                kind_s1 = K_NAN;
            else if (inf_a || inf_b)
                kind_s1 = K_INF;
            else if (zero_a || zero_b)
                kind_s1 = K_ZERO;
        end

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                sign1_reg <= 1'b0;
                kind1_reg <= 2'd0;
                exp1_reg  <= '0;
                ma1_reg   <= '0;
                mb1_reg   <= '0;
                sign2_reg <= 1'b0;
                kind2_reg <= 2'd0;
                exp2_reg  <= '0;
                prod2_reg <= '0;
                out_reg   <= '0;
            end else if (adv) begin
                sign1_reg <= op_a[31] ^ op_b[31];
                kind1_reg <= kind_s1;
                exp1_reg  <= exp_sum;
                ma1_reg   <= {1'b1, op_a[22:0]};
                mb1_reg   <= {1'b1, op_b[22:0]};
                sign2_reg <= sign1_reg;
                kind2_reg <= kind1_reg;
                exp2_reg  <= exp1_reg;
                prod2_reg <= ma1_reg * mb1_reg;
                if (valid2_reg)
                    out_reg <= res_next;
            end
        end

        // Product lies in [1,4): bit 47 set means one extra right shift
        always_comb begin
            frac   = prod2_reg[45:23];
            guard  = prod2_reg[22];
            rnd    = prod2_reg[21];
            sticky = |prod2_reg[20:0];
            exp_n  = exp2_reg;
            if (prod2_reg[47]) begin
                frac   = prod2_reg[46:24];
                guard  = prod2_reg[23];
                rnd    = prod2_reg[22];
                sticky = |prod2_reg[21:0];
                exp_n  = exp2_reg + 10'sd1;
            end
            round_up        = guard & (rnd | sticky | frac[0]);
            {carry, frac_r} = {1'b0, frac} + {23'd0, round_up};
            exp_f           = carry ? exp_n + 10'sd1 : exp_n;
            inexact         = guard | rnd | sticky;

            res_next = {1'b0, 8'hFF, 1'b1, 22'd0};
            flg_next = 4'b1000;
            case (kind2_reg)
                K_NAN: begin
                    res_next = {1'b0, 8'hFF, 1'b1, 22'd0};
                    flg_next = 4'b1000;
                end
                K_INF: begin
                    res_next = {sign2_reg, 8'hFF, 23'd0};
                    flg_next = 4'b0000;
                end
                K_ZERO: begin
                    res_next = {sign2_reg, 31'd0};
                    flg_next = 4'b0000;
                end
                default: begin
                    if (exp_f >= 10'sd255) begin
                        res_next = {sign2_reg, 8'hFF, 23'd0};
                        flg_next = 4'b0110;
                    end else if (exp_f <= 10'sd0) begin
                        res_next = {sign2_reg, 31'd0};
                        flg_next = 4'b0011;
                    end else begin
                        res_next = {sign2_reg, exp_f[7:0], frac_r};
                        flg_next = {3'b000, inexact};
                    end
                end
            endcase
        end

        assign lane_flags_next[gi] = flg_next;
        assign out[gi*32 +: 32]    = out_reg;
    end
endmodule
